ps2_keyboard: RTL
=================

PS2_KEYBOARD -- requirements
Module: ps2_keyboard

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: consecutive identical samples needed to accept a ps2_clk level change.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 25000: clk25 cycles without a falling edge before an incomplete frame is aborted (1 ms at 25 MHz).
REQ-003 SHALL have port clk25, input, 1 bit: single system clock; all logic runs on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port ps2_clk, input, 1 bit: keyboard clock, asynchronous to clk25.
REQ-006 SHALL have port ps2_din, input, 1 bit: keyboard data, asynchronous to clk25.
REQ-007 SHALL have port enable, input, 1 bit: CPU clock-enable strobe.
REQ-008 SHALL have port rd_en, input, 1 bit: active-high CPU read strobe.
REQ-009 SHALL have port address, input, 1 bit: 0 selects KBD data, 1 selects KBDCR status.
REQ-010 SHALL have port dout, output, 8 bits: CPU read data.
REQ-011 SHALL have port clr_screen, output, 1 bit: one-cycle pulse on F11 make; drives the display clear input.
REQ-012 SHALL have port reset_req, output, 1 bit: one-cycle pulse on F12 make.

Function
REQ-013 SHALL pass ps2_clk and ps2_din through 2-flop synchronisers, then filter ps2_clk per FILTER_LEN; data is sampled on a falling edge of the filtered clock.
REQ-014 SHALL run a frame FSM IDLE -> DATA (8 bits, LSB first) -> PARITY -> STOP -> IDLE; in IDLE, a falling edge with data 1 is treated as a false start and ignored.
REQ-015 SHALL accept a frame only with odd parity (XOR of the 8 data bits and the parity bit = 1) and stop bit = 1; otherwise it discards the frame silently and returns to IDLE.
REQ-016 SHALL return to IDLE and discard the partial frame when TIMEOUT_CYCLES elapse in any state other than IDLE.
REQ-017 SHALL present each accepted scancode to the decoder as a one-cycle strobe, one cycle after the stop-bit edge.
REQ-018 SHALL set the ext flag on 0xE0 and the brk flag on 0xF0; the next non-prefix code consumes and clears both flags.
REQ-019 SHALL track shift state: 0x12/0x59 make sets it, break clears it. SHALL track ctrl state: 0x14 or E0 0x14 make sets it, break clears it.
REQ-020 SHALL ignore break codes for all other keys, and ignore every other E0-prefixed code.
REQ-021 SHALL translate make codes to 7-bit ASCII, Set 2 US layout: letters always uppercase; digits and punctuation use shifted glyphs while shift is held; Enter 0x5A -> 0x0D; Backspace 0x66 -> 0x5F; Esc 0x76 -> 0x1B; Space 0x29 -> 0x20.
REQ-022 SHALL, while ctrl is held, translate letter keys to (uppercase ASCII AND 0x1F).
REQ-023 SHALL discard unmapped codes, producing no character.
REQ-024 SHALL produce one character per typematic repeat make, with no break code required between repeats.
REQ-025 SHALL, on a new character with ready = 0, load kbd_data = {1, ascii[6:0]} and set ready the next cycle.
REQ-026 SHALL, on a new character with ready = 1, drop the new character and leave kbd_data unchanged.
REQ-027 SHALL drive dout combinationally: kbd_data when address = 0, {ready, 7'b0} when address = 1.
REQ-028 SHALL clear ready on a cycle with enable & rd_en & address = 0; if a new character arrives in that same cycle, it is loaded and ready stays 1.
REQ-029 SHALL generate the clr_screen (F11, 0x78) and reset_req (F12, 0x07) pulses on make only; these keys produce no character.

Reset
REQ-030 SHALL, while rst_n = 0, force FSM to IDLE; clear bit count, timeout counter, filter, ext, brk, shift, ctrl, ready, kbd_data; drive dout = 0x00, clr_screen = 0, reset_req = 0.
REQ-031 SHALL discard any partial frame when reset asserts mid-frame; the first full frame after release decodes normally.

Structure
REQ-032 SHALL place the FSM state encoding, prefix/modifier scancode constants and special ASCII constants in shared package ps2_pkg.
REQ-033 SHALL implement sync, filter, frame FSM and timeout in sub-module ps2_rx (outputs: code[7:0], code_valid); translation and the CPU register stay in ps2_keyboard.

Verification
REQ-034 SHALL cover: frame 0x1C with parity 0, stop 1 -> ready = 1; address 1 reads 0x80; address 0 reads 0xC1; ready = 0 after the read.
REQ-035 SHALL cover: 0x12, 0x16, F0 16, F0 12 -> exactly one character, 0xA1 ('!'); shift clear afterwards.
REQ-036 SHALL cover: 0x1C with parity 1, and a separate 0x1C frame with stop 0 -> ready stays 0, no character.
REQ-037 SHALL cover: 5 bits sent, 1.2 ms idle, then a valid 0x5A frame -> kbd_data = 0x8D.
REQ-038 SHALL cover: 0x1C then 0x32 with no read between -> a read returns 0xC1, and ready = 0 afterwards.
REQ-039 SHALL cover: 0x78 -> clr_screen high for exactly 1 cycle, ready unchanged; 0x14, 0x21 -> kbd_data = 0x83.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver and scancode translator.
package ps2_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_F11    = 8'h78;
    localparam logic [7:0] SC_F12    = 8'h07;

    localparam logic [6:0] ASCII_CR    = 7'h0D;
    localparam logic [6:0] ASCII_BS    = 7'h5F;
    localparam logic [6:0] ASCII_ESC   = 7'h1B;
    localparam logic [6:0] ASCII_SPACE = 7'h20;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronisers, clock glitch filter, frame FSM and inactivity timeout.
module ps2_rx #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 25000
) (
    input  logic       clk25,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_din,
    output logic [7:0] code,
    output logic       code_valid
);
    import ps2_pkg::*;

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    din_sync;
    logic          clk_filt;
    logic [FW-1:0] filt_cnt;
    logic          fall;
    logic          din_smp;

    rx_state_t     state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par;
    logic [TW-1:0] tmo;

    // Filtered clock only follows the input after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync <= '1;
            din_sync <= '1;
            clk_filt <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
            din_smp  <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            din_sync <= {din_sync[0], ps2_din};
            fall     <= 1'b0;
            if (clk_sync[1] == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_sync[1];
                filt_cnt <= '0;
                fall     <= ~clk_sync[1];
                din_smp  <= din_sync[1];
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RX_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par        <= 1'b0;
            tmo        <= '0;
            code       <= '0;
            code_valid <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            if (state == RX_IDLE || fall)
                tmo <= '0;
            else
                tmo <= tmo + TW'(1);

            if (state != RX_IDLE && !fall && tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                state <= RX_IDLE;
            end else if (fall) begin
                case (state)
                    RX_IDLE: begin
                        if (!din_smp) begin
                            state   <= RX_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    RX_DATA: begin
                        shreg   <= {din_smp, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= RX_PARITY;
                    end
                    RX_PARITY: begin
                        par   <= din_smp;
                        state <= RX_STOP;
                    end
                    RX_STOP: begin
                        if (din_smp && (^{shreg, par})) begin
                            code       <= shreg;
                            code_valid <= 1'b1;
                        end
                        state <= RX_IDLE;
                    end
                    default: state <= RX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard to CPU register bridge: Set 2 scancode decode, ASCII translation, KBD/KBDCR registers.
module ps2_keyboard #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 25000
) (
    input  logic       clk25,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_din,
    input  logic       enable,
    input  logic       rd_en,
    input  logic       address,
    output logic [7:0] dout,
    output logic       clr_screen,
    output logic       reset_req
);
    import ps2_pkg::*;

    logic [7:0] code;
    logic       code_valid;
    logic       ext, brk, shift, ctrl, ready;
    logic [7:0] kbd_data;
    logic [7:0] xl;
    logic [6:0] ascii;
    logic       plain_make, char_valid, cpu_read;

    ps2_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk25     (clk25),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_din   (ps2_din),
        .code      (code),
        .code_valid(code_valid)
    );

    // Result is {hit, ascii}; a clear top bit means the code has no character.
    function automatic logic [7:0] xlate(input logic [7:0] sc, input logic sh);
        logic [7:0] r;
        r = '0;
        case (sc)
            8'h1C: r = {1'b1, 7'h41};
            8'h32: r = {1'b1, 7'h42};
            8'h21: r = {1'b1, 7'h43};
            8'h23: r = {1'b1, 7'h44};
            8'h24: r = {1'b1, 7'h45};
            8'h2B: r = {1'b1, 7'h46};
            8'h34: r = {1'b1, 7'h47};
            8'h33: r = {1'b1, 7'h48};
            8'h43: r = {1'b1, 7'h49};
            8'h3B: r = {1'b1, 7'h4A};
            8'h42: r = {1'b1, 7'h4B};
            8'h4B: r = {1'b1, 7'h4C};
            8'h3A: r = {1'b1, 7'h4D};
            8'h31: r = {1'b1, 7'h4E};
            8'h44: r = {1'b1, 7'h4F};
            8'h4D: r = {1'b1, 7'h50};
            8'h15: r = {1'b1, 7'h51};
            8'h2D: r = {1'b1, 7'h52};
            8'h1B: r = {1'b1, 7'h53};
            8'h2C: r = {1'b1, 7'h54};
            8'h3C: r = {1'b1, 7'h55};
            8'h2A: r = {1'b1, 7'h56};
            8'h1D: r = {1'b1, 7'h57};
            8'h22: r = {1'b1, 7'h58};
            8'h35: r = {1'b1, 7'h59};
            8'h1A: r = {1'b1, 7'h5A};
            8'h45: r = {1'b1, sh ? 7'h29 : 7'h30};
            8'h16: r = {1'b1, sh ? 7'h21 : 7'h31};
            8'h1E: r = {1'b1, sh ? 7'h40 : 7'h32};
            8'h26: r = {1'b1, sh ? 7'h23 : 7'h33};
            8'h25: r = {1'b1, sh ? 7'h24 : 7'h34};
            8'h2E: r = {1'b1, sh ? 7'h25 : 7'h35};
            8'h36: r = {1'b1, sh ? 7'h5E : 7'h36};
            8'h3D: r = {1'b1, sh ? 7'h26 : 7'h37};
            8'h3E: r = {1'b1, sh ? 7'h2A : 7'h38};
            8'h46: r = {1'b1, sh ? 7'h28 : 7'h39};
            8'h0E: r = {1'b1, sh ? 7'h7E : 7'h60};
            8'h4E: r = {1'b1, sh ? 7'h5F : 7'h2D};
            8'h55: r = {1'b1, sh ? 7'h2B : 7'h3D};
            8'h54: r = {1'b1, sh ? 7'h7B : 7'h5B};
            8'h5B: r = {1'b1, sh ? 7'h7D : 7'h5D};
            8'h5D: r = {1'b1, sh ? 7'h7C : 7'h5C};
            8'h4C: r = {1'b1, sh ? 7'h3A : 7'h3B};
            8'h52: r = {1'b1, sh ? 7'h22 : 7'h27};
            8'h41: r = {1'b1, sh ? 7'h3C : 7'h2C};
            8'h49: r = {1'b1, sh ? 7'h3E : 7'h2E};
            8'h4A: r = {1'b1, sh ? 7'h3F : 7'h2F};
            8'h5A: r = {1'b1, ASCII_CR};
            8'h66: r = {1'b1, ASCII_BS};
            8'h76: r = {1'b1, ASCII_ESC};
            8'h29: r = {1'b1, ASCII_SPACE};
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        xl    = xlate(code, shift);
        ascii = xl[6:0];
        // Only letter keys translate into the A..Z range, so the range test identifies them.
        if (ctrl && ascii >= 7'h41 && ascii <= 7'h5A)
            ascii = ascii & 7'h1F;
        plain_make = code_valid && code != SC_EXT && code != SC_BRK && !ext && !brk;
        char_valid = plain_make && xl[7];
        cpu_read   = enable && rd_en && !address;
    end

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            ext        <= 1'b0;
            brk        <= 1'b0;
            shift      <= 1'b0;
            ctrl       <= 1'b0;
            ready      <= 1'b0;
            kbd_data   <= '0;
            clr_screen <= 1'b0;
            reset_req  <= 1'b0;
        end else begin
            clr_screen <= plain_make && code == SC_F11;
            reset_req  <= plain_make && code == SC_F12;

            if (code_valid) begin
                if (code == SC_EXT) begin
                    ext <= 1'b1;
                end else if (code == SC_BRK) begin
                    brk <= 1'b1;
                end else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    if (!ext && (code == SC_LSHIFT || code == SC_RSHIFT))
                        shift <= ~brk;
                    if (code == SC_CTRL)
                        ctrl <= ~brk;
                end
            end

            if (char_valid && (!ready || cpu_read)) begin
                kbd_data <= {1'b1, ascii};
                ready    <= 1'b1;
            end else if (cpu_read) begin
                ready <= 1'b0;
            end
        end
    end

    always_comb dout = address ? {ready, 7'b0} : kbd_data;

endmodule
